// File: rtl/age_issue_queue.sv
// Out-of-order issue queue. Operands wake up from the result broadcasts, and the oldest ready
// entries are picked through a per-entry age matrix.
module age_issue_queue #(
   parameter int DEPTH         = 16,
   parameter int DISPATCH_NUM  = 4,
   parameter int ISSUE_NUM     = 4,
   parameter int WB_NUM        = 4,
   parameter int PRF_WIDTH     = 6,
   parameter int PAYLOAD_WIDTH = 74,
   parameter int CW            = $clog2(DEPTH + 1)
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  flush,
   input  logic [DISPATCH_NUM-1:0]               disp_valid,
   output logic                                  disp_ready,
   input  logic [DISPATCH_NUM*PAYLOAD_WIDTH-1:0] disp_payload,
   input  logic [DISPATCH_NUM*PRF_WIDTH-1:0]     disp_prs1,
   input  logic [DISPATCH_NUM*PRF_WIDTH-1:0]     disp_prs2,
   input  logic [DISPATCH_NUM*PRF_WIDTH-1:0]     disp_prd,
   input  logic [DISPATCH_NUM-1:0]               disp_prs1_v,
   input  logic [DISPATCH_NUM-1:0]               disp_prs2_v,
   input  logic [DISPATCH_NUM-1:0]               disp_prd_v,
   input  logic [DISPATCH_NUM-1:0]               disp_prs1_rdy,
   input  logic [DISPATCH_NUM-1:0]               disp_prs2_rdy,
   input  logic [WB_NUM-1:0]                     wb_valid,
   input  logic [WB_NUM*PRF_WIDTH-1:0]           wb_tag,
   output logic [ISSUE_NUM-1:0]                  iss_valid,
   output logic [ISSUE_NUM*PAYLOAD_WIDTH-1:0]    iss_payload,
   output logic [ISSUE_NUM*PRF_WIDTH-1:0]        iss_prs1,
   output logic [ISSUE_NUM*PRF_WIDTH-1:0]        iss_prs2,
   output logic [ISSUE_NUM*PRF_WIDTH-1:0]        iss_prd,
   output logic [ISSUE_NUM-1:0]                  iss_prd_v,
   output logic [CW-1:0]                         count,
   output logic                                  full
);

   localparam int IW = $clog2(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] DISP_C  = CW'(DISPATCH_NUM);

   logic [DEPTH-1:0]         ent_valid;
   logic [DEPTH-1:0]         ent_rdy1;
   logic [DEPTH-1:0]         ent_rdy2;
   logic [DEPTH-1:0]         ent_age [DEPTH];
   logic [PAYLOAD_WIDTH-1:0] ent_payload [DEPTH];
   logic [PRF_WIDTH-1:0]     ent_prs1 [DEPTH];
   logic [PRF_WIDTH-1:0]     ent_prs2 [DEPTH];
   logic [PRF_WIDTH-1:0]     ent_prd [DEPTH];
   logic [DEPTH-1:0]         ent_prs1_v;
   logic [DEPTH-1:0]         ent_prs2_v;
   logic [DEPTH-1:0]         ent_prd_v;

   logic                     do_disp;
   logic [IW-1:0]            slot [DISPATCH_NUM];
   logic [IW-1:0]            lane_idx [DISPATCH_NUM];
   logic [DISPATCH_NUM-1:0]  lane_we;
   logic [DEPTH-1:0]         lane_row [DISPATCH_NUM];
   logic [DISPATCH_NUM-1:0]  lane_rdy1;
   logic [DISPATCH_NUM-1:0]  lane_rdy2;
   logic [DISPATCH_NUM-1:0]  lane_hit1;
   logic [DISPATCH_NUM-1:0]  lane_hit2;
   logic [DEPTH-1:0]         ent_hit1;
   logic [DEPTH-1:0]         ent_hit2;
   logic [DEPTH-1:0]         req;
   logic [CW-1:0]            older_cnt [DEPTH];
   logic [ISSUE_NUM-1:0]     sel_valid;
   logic [IW-1:0]            sel_idx [ISSUE_NUM];
   logic [DEPTH-1:0]         iss_mask;
   logic [CW-1:0]            disp_n;
   logic [CW-1:0]            iss_n;

   // Readiness depends only on registered occupancy, so slots freed by issue this cycle are not offered.
   assign disp_ready = (DEPTH_C - count) >= DISP_C;
   assign full       = (count == DEPTH_C);
   assign do_disp    = disp_ready & ~flush;
   assign req        = ent_valid & ent_rdy1 & ent_rdy2;
   assign disp_n     = CW'($countones(disp_valid & {DISPATCH_NUM{do_disp}}));
   assign iss_n      = CW'($countones(sel_valid));

   // k-th lowest free entry for k in 0..DISPATCH_NUM-1
   always_comb begin
      int fcnt;
      fcnt = 0;
      for (int k = 0; k < DISPATCH_NUM; k++) slot[k] = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!ent_valid[i]) begin
            for (int k = 0; k < DISPATCH_NUM; k++) begin
               if (fcnt == k) slot[k] = IW'(i);
            end
            fcnt++;
         end
      end
   end

   always_comb begin
      ent_hit1  = '0;
      ent_hit2  = '0;
      lane_hit1 = '0;
      lane_hit2 = '0;
      for (int w = 0; w < WB_NUM; w++) begin
         if (wb_valid[w]) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (ent_prs1[i] == wb_tag[w*PRF_WIDTH +: PRF_WIDTH]) ent_hit1[i] = 1'b1;
               if (ent_prs2[i] == wb_tag[w*PRF_WIDTH +: PRF_WIDTH]) ent_hit2[i] = 1'b1;
            end
            for (int l = 0; l < DISPATCH_NUM; l++) begin
               if (disp_prs1[l*PRF_WIDTH +: PRF_WIDTH] == wb_tag[w*PRF_WIDTH +: PRF_WIDTH]) lane_hit1[l] = 1'b1;
               if (disp_prs2[l*PRF_WIDTH +: PRF_WIDTH] == wb_tag[w*PRF_WIDTH +: PRF_WIDTH]) lane_hit2[l] = 1'b1;
            end
         end
      end
   end

   // Port p takes the requester with exactly p older requesters.
   always_comb begin
      sel_valid = '0;
      iss_mask  = '0;
      for (int p = 0; p < ISSUE_NUM; p++) sel_idx[p] = '0;
      for (int i = 0; i < DEPTH; i++) begin
         older_cnt[i] = CW'($countones(ent_age[i] & req));
         if (req[i] && !flush) begin
            for (int p = 0; p < ISSUE_NUM; p++) begin
               if (older_cnt[i] == CW'(p)) begin
                  sel_valid[p] = 1'b1;
                  sel_idx[p]   = IW'(i);
                  iss_mask[i]  = 1'b1;
               end
            end
         end
      end
   end

   // Lane allocation by rank among valid lanes; new rows see surviving entries plus lower lanes.
   always_comb begin
      int rank;
      logic [DEPTH-1:0] prior;
      rank  = 0;
      prior = '0;
      for (int l = 0; l < DISPATCH_NUM; l++) begin
         lane_idx[l] = '0;
         for (int k = 0; k < DISPATCH_NUM; k++) begin
            if (rank == k) lane_idx[l] = slot[k];
         end
         lane_we[l]   = do_disp & disp_valid[l];
         lane_row[l]  = (ent_valid & ~iss_mask) | prior;
         lane_rdy1[l] = disp_prs1_rdy[l] | ~disp_prs1_v[l] | lane_hit1[l];
         lane_rdy2[l] = disp_prs2_rdy[l] | ~disp_prs2_v[l] | lane_hit2[l];
         if (lane_we[l]) prior[lane_idx[l]] = 1'b1;
         if (disp_valid[l]) rank++;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent_valid <= '0;
         ent_rdy1  <= '0;
         ent_rdy2  <= '0;
         for (int i = 0; i < DEPTH; i++) ent_age[i] <= '0;
         count     <= '0;
         iss_valid <= '0;
      end else if (flush) begin
         ent_valid <= '0;
         count     <= '0;
         iss_valid <= '0;
      end else begin
         ent_valid <= ent_valid & ~iss_mask;
         ent_rdy1  <= ent_rdy1 | (ent_hit1 & ent_prs1_v & ent_valid);
         ent_rdy2  <= ent_rdy2 | (ent_hit2 & ent_prs2_v & ent_valid);
         for (int i = 0; i < DEPTH; i++) ent_age[i] <= ent_age[i] & ~iss_mask;
         for (int l = 0; l < DISPATCH_NUM; l++) begin
            if (lane_we[l]) begin
               ent_valid[lane_idx[l]] <= 1'b1;
               ent_rdy1[lane_idx[l]]  <= lane_rdy1[l];
               ent_rdy2[lane_idx[l]]  <= lane_rdy2[l];
               ent_age[lane_idx[l]]   <= lane_row[l];
            end
         end
         count     <= count + disp_n - iss_n;
         iss_valid <= sel_valid;
      end
   end

   always_ff @(posedge clk) begin
      for (int l = 0; l < DISPATCH_NUM; l++) begin
         if (lane_we[l]) begin
            ent_payload[lane_idx[l]] <= disp_payload[l*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
            ent_prs1[lane_idx[l]]    <= disp_prs1[l*PRF_WIDTH +: PRF_WIDTH];
            ent_prs2[lane_idx[l]]    <= disp_prs2[l*PRF_WIDTH +: PRF_WIDTH];
            ent_prd[lane_idx[l]]     <= disp_prd[l*PRF_WIDTH +: PRF_WIDTH];
            ent_prs1_v[lane_idx[l]]  <= disp_prs1_v[l];
            ent_prs2_v[lane_idx[l]]  <= disp_prs2_v[l];
            ent_prd_v[lane_idx[l]]   <= disp_prd_v[l];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iss_payload <= '0;
         iss_prs1    <= '0;
         iss_prs2    <= '0;
         iss_prd     <= '0;
         iss_prd_v   <= '0;
      end else begin
         for (int p = 0; p < ISSUE_NUM; p++) begin
            iss_payload[p*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] <= ent_payload[sel_idx[p]];
            iss_prs1[p*PRF_WIDTH +: PRF_WIDTH]            <= ent_prs1[sel_idx[p]];
            iss_prs2[p*PRF_WIDTH +: PRF_WIDTH]            <= ent_prs2[sel_idx[p]];
            iss_prd[p*PRF_WIDTH +: PRF_WIDTH]             <= ent_prd[sel_idx[p]];
            iss_prd_v[p]                                  <= ent_prd_v[sel_idx[p]];
         end
      end
   end

endmodule

// File: tb/tb_age_issue_queue.sv
// Directed bench for age_issue_queue with default parameters; every expected value below is
// worked out by hand from the queue's behaviour.
module tb_age_issue_queue;

   localparam int PW = 74;
   localparam int TW = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush;
   logic [3:0]    disp_valid;
   logic          disp_ready;
   logic [4*PW-1:0] disp_payload;
   logic [4*TW-1:0] disp_prs1, disp_prs2, disp_prd;
   logic [3:0]    disp_prs1_v, disp_prs2_v, disp_prd_v, disp_prs1_rdy, disp_prs2_rdy;
   logic [3:0]    wb_valid;
   logic [4*TW-1:0] wb_tag;
   logic [3:0]    iss_valid;
   logic [4*PW-1:0] iss_payload;
   logic [4*TW-1:0] iss_prs1, iss_prs2, iss_prd;
   logic [3:0]    iss_prd_v;
   logic [4:0]    count;
   logic          full;

   int checks = 0;
   int failures = 0;

   age_issue_queue dut (
      .clk(clk), .rst(rst), .flush(flush),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_payload(disp_payload),
      .disp_prs1(disp_prs1), .disp_prs2(disp_prs2), .disp_prd(disp_prd),
      .disp_prs1_v(disp_prs1_v), .disp_prs2_v(disp_prs2_v), .disp_prd_v(disp_prd_v),
      .disp_prs1_rdy(disp_prs1_rdy), .disp_prs2_rdy(disp_prs2_rdy),
      .wb_valid(wb_valid), .wb_tag(wb_tag),
      .iss_valid(iss_valid), .iss_payload(iss_payload),
      .iss_prs1(iss_prs1), .iss_prs2(iss_prs2), .iss_prd(iss_prd), .iss_prd_v(iss_prd_v),
      .count(count), .full(full)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      flush = 0; disp_valid = 0; disp_payload = '0;
      disp_prs1 = '0; disp_prs2 = '0; disp_prd = '0;
      disp_prs1_v = 0; disp_prs2_v = 0; disp_prd_v = 0;
      disp_prs1_rdy = 0; disp_prs2_rdy = 0;
      wb_valid = 0; wb_tag = '0;
   endtask

   task automatic set_lane(input int l, input logic [PW-1:0] pl,
                           input logic [TW-1:0] s1, input logic s1v, input logic s1r,
                           input logic [TW-1:0] s2, input logic s2v, input logic s2r,
                           input logic [TW-1:0] d);
      disp_valid[l] = 1'b1;
      disp_payload[l*PW +: PW] = pl;
      disp_prs1[l*TW +: TW] = s1; disp_prs1_v[l] = s1v; disp_prs1_rdy[l] = s1r;
      disp_prs2[l*TW +: TW] = s2; disp_prs2_v[l] = s2v; disp_prs2_rdy[l] = s2r;
      disp_prd[l*TW +: TW] = d;   disp_prd_v[l] = 1'b1;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1;
      step();
      rst = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1;
      step(); step();
      checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", full); end
      checks++; if (disp_ready !== 1'b1) begin failures++; $display("FAIL reset_disp_ready got=%0b exp=1", disp_ready); end
      checks++; if (iss_valid !== 4'h0) begin failures++; $display("FAIL reset_iss_valid got=%0h exp=0", iss_valid); end
      checks++; if (iss_payload !== '0) begin failures++; $display("FAIL reset_iss_payload got=%0h exp=0", iss_payload); end
      checks++; if ({iss_prs1, iss_prs2, iss_prd, iss_prd_v} !== '0) begin failures++; $display("FAIL reset_iss_tags got=%0h exp=0", {iss_prs1, iss_prs2, iss_prd, iss_prd_v}); end
      rst = 0;
      step();
   endtask

   task automatic test_four_lane();
      do_reset();
      for (int l = 0; l < 4; l++) set_lane(l, 74'(100 + l), 6'(1 + l), 1, 1, 6'(5 + l), 1, 1, 6'(10 + l));
      step();
      clear_inputs();
      checks++; if (count !== 5'd4) begin failures++; $display("FAIL four_lane_count1 got=%0d exp=4", count); end
      checks++; if (iss_valid !== 4'h0) begin failures++; $display("FAIL four_lane_early got=%0h exp=0", iss_valid); end
      step();
      checks++; if (iss_valid !== 4'hf) begin failures++; $display("FAIL four_lane_valid got=%0h exp=f", iss_valid); end
      for (int p = 0; p < 4; p++) begin
         checks++; if (iss_payload[p*PW +: PW] !== 74'(100 + p)) begin failures++; $display("FAIL four_lane_payload%0d got=%0d exp=%0d", p, iss_payload[p*PW +: PW], 100 + p); end
         checks++; if (iss_prd[p*TW +: TW] !== 6'(10 + p) || iss_prs1[p*TW +: TW] !== 6'(1 + p) || iss_prs2[p*TW +: TW] !== 6'(5 + p) || iss_prd_v[p] !== 1'b1) begin
            failures++; $display("FAIL four_lane_tags%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", p, iss_prs1[p*TW +: TW], iss_prs2[p*TW +: TW], iss_prd[p*TW +: TW], 1 + p, 5 + p, 10 + p);
         end
      end
      checks++; if (count !== 5'd0) begin failures++; $display("FAIL four_lane_count2 got=%0d exp=0", count); end
      step();
      checks++; if (iss_valid !== 4'h0) begin failures++; $display("FAIL four_lane_reissue got=%0h exp=0", iss_valid); end
   endtask

   task automatic test_wakeup();
      do_reset();
      set_lane(0, 74'h3A5, 6'd7, 1, 0, 6'd0, 0, 0, 6'd12);
      step();
      clear_inputs();
      step();
      checks++; if (iss_valid !== 4'h0) begin failures++; $display("FAIL wakeup_not_ready got=%0h exp=0", iss_valid); end
      wb_valid = 4'b0100; wb_tag[2*TW +: TW] = 6'd8;
      step();
      wb_valid = 4'b0010; wb_tag[1*TW +: TW] = 6'd7;
      step();
      clear_inputs();
      checks++; if (iss_valid !== 4'h0) begin failures++; $display("FAIL wakeup_request_cycle got=%0h exp=0", iss_valid); end
      step();
      checks++; if (iss_valid !== 4'h1) begin failures++; $display("FAIL wakeup_issue got=%0h exp=1", iss_valid); end
      checks++; if (iss_payload[PW-1:0] !== 74'h3A5) begin failures++; $display("FAIL wakeup_payload got=%0h exp=3a5", iss_payload[PW-1:0]); end
      checks++; if (count !== 5'd0) begin failures++; $display("FAIL wakeup_count got=%0d exp=0", count); end
   endtask

   task automatic test_same_cycle_wb();
      do_reset();
      set_lane(0, 74'h99, 6'd0, 0, 0, 6'd9, 1, 0, 6'd13);
      wb_valid = 4'b1000; wb_tag[3*TW +: TW] = 6'd9;
      step();
      clear_inputs();
      checks++; if (count !== 5'd1) begin failures++; $display("FAIL same_wb_count got=%0d exp=1", count); end
      step();
      checks++; if (iss_valid !== 4'h1) begin failures++; $display("FAIL same_wb_issue got=%0h exp=1", iss_valid); end
      checks++; if (iss_payload[PW-1:0] !== 74'h99) begin failures++; $display("FAIL same_wb_payload got=%0h exp=99", iss_payload[PW-1:0]); end
   endtask

   task automatic test_fill();
      do_reset();
      for (int b = 0; b < 4; b++) begin
         for (int l = 0; l < 4; l++) begin
            if (b * 4 + l < 13) set_lane(l, 74'(200 + b * 4 + l), 6'(20 + b * 4 + l), 1, 0, 6'd0, 0, 0, 6'd1);
         end
         step();
         clear_inputs();
      end
      checks++; if (count !== 5'd13) begin failures++; $display("FAIL fill_count got=%0d exp=13", count); end
      checks++; if (disp_ready !== 1'b0) begin failures++; $display("FAIL fill_ready got=%0b exp=0", disp_ready); end
      checks++; if (full !== 1'b0) begin failures++; $display("FAIL fill_full got=%0b exp=0", full); end
      for (int l = 0; l < 4; l++) set_lane(l, 74'h777, 6'd2, 0, 1, 6'd0, 0, 1, 6'd3);
      step();
      clear_inputs();
      checks++; if (count !== 5'd13) begin failures++; $display("FAIL fill_blocked got=%0d exp=13", count); end
      wb_valid = 4'b0001; wb_tag[TW-1:0] = 6'd25;
      step();
      clear_inputs();
      step();
      checks++; if (iss_valid !== 4'h1 || iss_payload[PW-1:0] !== 74'd205) begin failures++; $display("FAIL fill_issue got=%0h/%0d exp=1/205", iss_valid, iss_payload[PW-1:0]); end
      checks++; if (count !== 5'd12 || disp_ready !== 1'b1) begin failures++; $display("FAIL fill_after_issue got=%0d/%0b exp=12/1", count, disp_ready); end
   endtask

   task automatic test_full();
      do_reset();
      for (int b = 0; b < 4; b++) begin
         for (int l = 0; l < 4; l++) set_lane(l, 74'(b * 4 + l), 6'd40, 1, 0, 6'd0, 0, 0, 6'd1);
         step();
         clear_inputs();
      end
      checks++; if (count !== 5'd16 || full !== 1'b1 || disp_ready !== 1'b0) begin failures++; $display("FAIL full_state got=%0d/%0b/%0b exp=16/1/0", count, full, disp_ready); end
   endtask

   task automatic test_age_order();
      do_reset();
      set_lane(0, 74'd50, 6'd0, 0, 0, 6'd0, 0, 0, 6'd2);
      set_lane(1, 74'd51, 6'd30, 1, 0, 6'd0, 0, 0, 6'd3);
      step();
      clear_inputs();
      step();
      checks++; if (iss_valid !== 4'h1 || iss_payload[PW-1:0] !== 74'd50) begin failures++; $display("FAIL age_x_issue got=%0h/%0d exp=1/50", iss_valid, iss_payload[PW-1:0]); end
      set_lane(0, 74'd52, 6'd31, 1, 0, 6'd0, 0, 0, 6'd4);
      step();
      clear_inputs();
      checks++; if (count !== 5'd2) begin failures++; $display("FAIL age_count got=%0d exp=2", count); end
      wb_valid = 4'b0011; wb_tag[0 +: TW] = 6'd31; wb_tag[TW +: TW] = 6'd30;
      step();
      clear_inputs();
      step();
      checks++; if (iss_valid !== 4'h3) begin failures++; $display("FAIL age_valid got=%0h exp=3", iss_valid); end
      checks++; if (iss_payload[0 +: PW] !== 74'd51 || iss_payload[PW +: PW] !== 74'd52) begin
         failures++; $display("FAIL age_order got=%0d,%0d exp=51,52", iss_payload[0 +: PW], iss_payload[PW +: PW]);
      end
   endtask

   task automatic test_flush();
      do_reset();
      set_lane(0, 74'd60, 6'd0, 0, 1, 6'd0, 0, 1, 6'd5);
      set_lane(1, 74'd61, 6'd22, 1, 0, 6'd0, 0, 1, 6'd6);
      step();
      clear_inputs();
      flush = 1;
      set_lane(0, 74'd62, 6'd0, 0, 1, 6'd0, 0, 1, 6'd7);
      wb_valid = 4'b0001; wb_tag[TW-1:0] = 6'd22;
      step();
      clear_inputs();
      checks++; if (count !== 5'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
      checks++; if (iss_valid !== 4'h0) begin failures++; $display("FAIL flush_iss got=%0h exp=0", iss_valid); end
      step();
      step();
      checks++; if (iss_valid !== 4'h0 || count !== 5'd0) begin failures++; $display("FAIL flush_later got=%0h/%0d exp=0/0", iss_valid, count); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int l = 0; l < 3; l++) set_lane(l, 74'(300 + l), 6'd33, 1, 0, 6'd0, 0, 0, 6'd8);
      step();
      clear_inputs();
      #2 rst = 1;
      #1;
      checks++; if (count !== 5'd0 || disp_ready !== 1'b1) begin failures++; $display("FAIL reset_mid got=%0d/%0b exp=0/1", count, disp_ready); end
      rst = 0;
      set_lane(0, 74'd77, 6'd0, 0, 1, 6'd0, 0, 1, 6'd9);
      step();
      clear_inputs();
      checks++; if (count !== 5'd1) begin failures++; $display("FAIL reset_mid_disp got=%0d exp=1", count); end
      step();
      checks++; if (iss_valid !== 4'h1 || iss_payload[PW-1:0] !== 74'd77) begin failures++; $display("FAIL reset_mid_issue got=%0h/%0d exp=1/77", iss_valid, iss_payload[PW-1:0]); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int b = 0; b < 4; b++) begin
         clear_inputs();
         if (b < 3) for (int l = 0; l < 4; l++) set_lane(l, 74'(400 + b * 4 + l), 6'd0, 0, 1, 6'd0, 0, 1, 6'd1);
         step();
         if (b > 0) begin
            checks++; if (iss_valid !== 4'hf || iss_payload[3*PW +: PW] !== 74'(400 + (b - 1) * 4 + 3)) begin
               failures++; $display("FAIL b2b_batch%0d got=%0h/%0d exp=f/%0d", b, iss_valid, iss_payload[3*PW +: PW], 400 + (b - 1) * 4 + 3);
            end
         end
         checks++; if (count !== ((b < 3) ? 5'd4 : 5'd0)) begin failures++; $display("FAIL b2b_count%0d got=%0d exp=%0d", b, count, (b < 3) ? 4 : 0); end
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_four_lane();
      test_wakeup();
      test_same_cycle_wb();
      test_fill();
      test_full();
      test_age_order();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
